gonso_wb_initiator: RTL

//  Wishbone classic single-beat initiator (bus master). Turns a valid/ready command stream into
//  one read/write cycle on the user-area Wishbone bus and returns a valid/ready response.

---
 rtl/gonso_wb_pkg.sv | 25 ++
 rtl/gonso_wb_watchdog.sv | 31 +++
 rtl/gonso_wb_initiator.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/gonso_wb_pkg.sv
// Shared types and constants for the gonso Wishbone initiator: FSM encoding,
// bus widths and the gonso register map.
package gonso_wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = 4;

  localparam logic [31:0] GONSO_REG0_ADDR = 32'h3003_0004;
  localparam logic [31:0] GONSO_REG1_ADDR = 32'h3003_0008;
  localparam logic [31:0] GONSO_REG2_ADDR = 32'h3003_000C;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2,
    ST_GAP  = 2'd3
  } wb_state_e;

  // Writes return zero so the consumer never sees stale slave data.
  function automatic logic [WB_DATA_W-1:0] ack_rdata(input logic we,
                                                     input logic [WB_DATA_W-1:0] dat);
    return we ? '0 : dat;
  endfunction

endpackage

// File: rtl/gonso_wb_watchdog.sv
// Bus-cycle watchdog: counts un-acknowledged BUS cycles and flags expiry so
// the initiator can abandon a transfer to a silent slave.
module gonso_wb_watchdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Holds at LIMIT once reached, so the counter can never wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/gonso_wb_initiator.sv
// Wishbone classic single-beat initiator: one valid/ready command becomes one
// bus cycle, answered by one valid/ready response (with timeout reporting).
module gonso_wb_initiator
  import gonso_wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [3:0]        cmd_sel,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [ADDR_W-1:0] wbm_adr_o,
  output logic [31:0]       wbm_dat_o,
  output logic [3:0]        wbm_sel_o,
  input  logic [31:0]       wbm_dat_i,
  input  logic              wbm_ack_i
);

  wb_state_e         state_q, state_nxt;
  logic              cmd_ready_nxt, rsp_valid_nxt, rsp_err_nxt, busy_nxt;
  logic [31:0]       rsp_rdata_nxt;
  logic              cyc_nxt, stb_nxt, we_nxt;
  logic [ADDR_W-1:0] adr_nxt;
  logic [31:0]       dat_nxt;
  logic [3:0]        sel_nxt;
  logic              wd_expired;

  gonso_wb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q == ST_IDLE),
    .enable ((state_q == ST_BUS) && !wbm_ack_i),
    .expired(wd_expired)
  );

  always_comb begin
    state_nxt     = state_q;
    cmd_ready_nxt = 1'b0;
    rsp_valid_nxt = rsp_valid;
    rsp_rdata_nxt = rsp_rdata;
    rsp_err_nxt   = rsp_err;
    cyc_nxt       = wbm_cyc_o;
    stb_nxt       = wbm_stb_o;
    we_nxt        = wbm_we_o;
    adr_nxt       = wbm_adr_o;
    dat_nxt       = wbm_dat_o;
    sel_nxt       = wbm_sel_o;

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready_nxt = 1'b1;
        if (cmd_valid && cmd_ready) begin
          cmd_ready_nxt = 1'b0;
          we_nxt        = cmd_we;
          adr_nxt       = cmd_addr;
          dat_nxt       = cmd_wdata;
          sel_nxt       = cmd_sel;
          cyc_nxt       = 1'b1;
          stb_nxt       = 1'b1;
          state_nxt     = ST_BUS;
        end
      end
      ST_BUS: begin
        // An ack in the expiry cycle still completes the transfer normally.
        if (wbm_ack_i) begin
          cyc_nxt       = 1'b0;
          stb_nxt       = 1'b0;
          rsp_rdata_nxt = ack_rdata(wbm_we_o, wbm_dat_i);
          rsp_err_nxt   = 1'b0;
          rsp_valid_nxt = 1'b1;
          state_nxt     = ST_RESP;
        end else if (wd_expired) begin
          cyc_nxt       = 1'b0;
          stb_nxt       = 1'b0;
          rsp_rdata_nxt = '0;
          rsp_err_nxt   = 1'b1;
          rsp_valid_nxt = 1'b1;
          state_nxt     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = ST_GAP;
        end
      end
      ST_GAP: begin
        // One dead cycle absorbs a late ack from a slow slave.
        cmd_ready_nxt = 1'b1;
        state_nxt     = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    busy_nxt = (state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      wbm_sel_o <= '0;
    end else begin
      state_q   <= state_nxt;
      cmd_ready <= cmd_ready_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_rdata <= rsp_rdata_nxt;
      rsp_err   <= rsp_err_nxt;
      busy      <= busy_nxt;
      wbm_cyc_o <= cyc_nxt;
      wbm_stb_o <= stb_nxt;
      wbm_we_o  <= we_nxt;
      wbm_adr_o <= adr_nxt;
      wbm_dat_o <= dat_nxt;
      wbm_sel_o <= sel_nxt;
    end
  end

endmodule
